// File: rtl/rbm_iter_sched.sv
// rbm_iter_sched: runs max_iter hidden/class sampler iterations and accumulates
// each class sample into result with per-element unsigned saturation.
// Optional watchdog on sampler waits: define RBM_SCHED_TIMEOUT_EN.
//
// state   | meaning
// S_IDLE  | waiting for start; result and iter_count hold
// S_H_RUN | hidden-layer sampler launched, waiting for h_done
// S_C_RUN | class-layer sampler launched, waiting for c_done
// S_DONE  | max_iter iterations accumulated; result and iter_count hold
module rbm_iter_sched #(
   parameter int output_bitlength = 12,
   parameter int out_dim          = 2,
   parameter int max_iter         = 1000,
   parameter int iter_width       = 16,
   parameter int timeout_cycles   = 256
) (
   input  logic                                  clock,
   input  logic                                  reset,
   input  logic                                  start,
   input  logic                                  abort,
   output logic                                  h_start,
   input  logic                                  h_done,
   output logic                                  c_start,
   input  logic                                  c_done,
   input  logic [out_dim*output_bitlength-1:0]   sample_in,
   output logic [out_dim*output_bitlength-1:0]   result,
   output logic [iter_width-1:0]                 iter_count,
   output logic                                  busy,
   output logic                                  finish,
   output logic                                  error
);

   localparam int OB = output_bitlength;
   localparam int RW = out_dim * output_bitlength;
   localparam logic [iter_width-1:0] ITER_LAST = iter_width'(max_iter);
   localparam logic [iter_width-1:0] ITER_ONE  = 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_H_RUN = 2'd1,
      S_C_RUN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                state, state_nxt;
   logic                  h_start_nxt, c_start_nxt;
   logic [RW-1:0]         result_nxt, sum_sat;
   logic [iter_width-1:0] iter_count_nxt, iter_inc;
   logic [OB:0]           elem_sum;
   logic                  wd_trip;

   assign busy   = (state == S_H_RUN) || (state == S_C_RUN);
   assign finish = (state == S_DONE);

   // element-wise add with a carry bit; a carry means clamp to all ones
   always_comb begin
      sum_sat  = '0;
      elem_sum = '0;
      for (int i = 0; i < out_dim; i++) begin
         elem_sum = {1'b0, result[i*OB +: OB]} + {1'b0, sample_in[i*OB +: OB]};
         sum_sat[i*OB +: OB] = elem_sum[OB] ? {OB{1'b1}} : elem_sum[OB-1:0];
      end
   end

   always_comb begin
      state_nxt      = state;
      h_start_nxt    = 1'b0;
      c_start_nxt    = 1'b0;
      result_nxt     = result;
      iter_count_nxt = iter_count;
      iter_inc       = iter_count + ITER_ONE;
      if (abort) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_nxt      = S_H_RUN;
                  h_start_nxt    = 1'b1;
                  result_nxt     = '0;
                  iter_count_nxt = '0;
               end
            end
            S_H_RUN: begin
               if (h_done) begin
                  state_nxt   = S_C_RUN;
                  c_start_nxt = 1'b1;
               end else if (wd_trip) begin
                  state_nxt = S_IDLE;
               end
            end
            S_C_RUN: begin
               if (c_done) begin
                  result_nxt     = sum_sat;
                  iter_count_nxt = iter_inc;
                  if (iter_inc == ITER_LAST) begin
                     state_nxt = S_DONE;
                  end else begin
                     state_nxt   = S_H_RUN;
                     h_start_nxt = 1'b1;
                  end
               end else if (wd_trip) begin
                  state_nxt = S_IDLE;
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         h_start    <= 1'b0;
         c_start    <= 1'b0;
         result     <= '0;
         iter_count <= '0;
      end else begin
         state      <= state_nxt;
         h_start    <= h_start_nxt;
         c_start    <= c_start_nxt;
         result     <= result_nxt;
         iter_count <= iter_count_nxt;
      end
   end

`ifdef RBM_SCHED_TIMEOUT_EN
   localparam int WD_W = $clog2(timeout_cycles + 1);
   localparam logic [WD_W-1:0] WD_LOAD = WD_W'(timeout_cycles - 1);
   localparam logic [WD_W-1:0] WD_ONE  = 1;

   logic [WD_W-1:0] wdog;
   logic            error_q;

   // down-counter reloaded on every state change; terminal count while waiting trips
   assign wd_trip = busy && (wdog == '0);
   assign error   = error_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wdog    <= WD_LOAD;
         error_q <= 1'b0;
      end else begin
         if (state_nxt != state)
            wdog <= WD_LOAD;
         else if (busy && (wdog != '0))
            wdog <= wdog - WD_ONE;
         if (!busy && (state_nxt == S_H_RUN))
            error_q <= 1'b0;
         else if (busy && (state_nxt == S_IDLE) && !abort)
            error_q <= 1'b1;
      end
   end
`else
   assign wd_trip = 1'b0;
   assign error   = 1'b0;
   // timeout_cycles only has meaning when the watchdog is built in
   if (timeout_cycles < 1) begin : g_timeout_unused
   end
`endif

endmodule

// File: doc/rbm_iter_sched.md
RBM_ITER_SCHED -- requirements
Module: rbm_iter_sched

Interface
REQ-001 SHALL have parameter output_bitlength, default 12, width of one class sample and one accumulated result element.
REQ-002 SHALL have parameter out_dim, default 2, number of class outputs.
REQ-003 SHALL have parameter max_iter, default 1000, sampling iterations per run; legal range is 1 to 2^iter_width-1.
REQ-004 SHALL have parameter iter_width, default 16, width of iter_count.
REQ-005 SHALL have parameter timeout_cycles, default 256, watchdog limit (used only under RBM_SCHED_TIMEOUT_EN).
REQ-006 SHALL have port clock, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-008 SHALL have port start, input, 1 bit, requests a new run; sampled in IDLE or DONE only.
REQ-009 SHALL have port abort, input, 1 bit, synchronous run cancel.
REQ-010 SHALL have port h_start, output, 1 bit, one-cycle pulse that launches the hidden-layer sampler.
REQ-011 SHALL have port h_done, input, 1 bit, hidden-layer sampler completion.
REQ-012 SHALL have port c_start, output, 1 bit, one-cycle pulse that launches the class-layer sampler.
REQ-013 SHALL have port c_done, input, 1 bit, class-layer sampler completion; sample_in is valid in the same cycle.
REQ-014 SHALL have port sample_in, input, out_dim*output_bitlength bits, packed class sample with element 0 in the LSBs.
REQ-015 SHALL have port result, output, out_dim*output_bitlength bits, packed cumulated result with the same packing as sample_in.
REQ-016 SHALL have port iter_count, output, iter_width bits, count of completed iterations.
REQ-017 SHALL have port busy, output, 1 bit, high in H_RUN and C_RUN.
REQ-018 SHALL have port finish, output, 1 bit, high in DONE.
REQ-019 SHALL have port error, output, 1 bit, sticky watchdog flag.

Function
REQ-020 SHALL implement states IDLE, H_RUN, C_RUN, DONE.
REQ-021 In IDLE or DONE, start=1 at edge N SHALL clear result and iter_count, clear error, enter H_RUN, and drive h_start=1 in cycle N+1 only.
REQ-022 In H_RUN, h_done=1 at edge M SHALL enter C_RUN and drive c_start=1 in cycle M+1 only; h_done is honoured in the same cycle as h_start.
REQ-023 In C_RUN, c_done=1 at edge K SHALL, on that edge, add each sample_in element into its result element and increment iter_count.
REQ-024 Result addition SHALL be unsigned per element and saturate at 2^output_bitlength-1.
REQ-025 After REQ-023, if the incremented iter_count equals max_iter the block SHALL enter DONE; otherwise it SHALL enter H_RUN with h_start=1 in cycle K+1.
REQ-026 h_done outside H_RUN and c_done outside C_RUN SHALL be ignored.
REQ-027 start while busy SHALL be ignored.
REQ-028 abort=1 in any state SHALL enter IDLE on that edge, hold result and iter_count, suppress pending start pulses, and take priority over done inputs and start.
REQ-029 In DONE, result and iter_count SHALL hold until the next start.

Reset
REQ-030 reset=0 SHALL immediately force IDLE with result=0, iter_count=0, h_start=0, c_start=0, busy=0, finish=0, error=0, independent of clock.
REQ-031 Reset deassertion SHALL take effect at the next rising edge with no start pulse generated.

Configuration
REQ-032 With macro RBM_SCHED_TIMEOUT_EN defined, a counter SHALL count cycles spent in H_RUN or C_RUN since the last state entry; reaching timeout_cycles without the expected done SHALL set error=1 and enter IDLE with result held.
REQ-033 Without RBM_SCHED_TIMEOUT_EN, no watchdog logic SHALL exist, waits SHALL be unbounded, and error SHALL be constant 0.

Verification
REQ-034 out_dim=2, max_iter=4; start; h_done 2 cycles after each h_start, c_done 3 cycles after each c_start, sample_in elements {0:1, 1:0} -> result elements {4,0}, iter_count=4, finish=1, exactly 4 h_start and 4 c_start pulses.
REQ-035 output_bitlength=3, max_iter=10, sample_in elements {1,1} -> result elements {7,7} (saturated), iter_count=10.
REQ-036 abort asserted in C_RUN of iteration 2 of 4, sample_in {1,1} -> IDLE, busy=0, finish=0, result {1,1}, iter_count=1, no further start pulses.
REQ-037 start pulsed again during H_RUN -> no effect; a later start in DONE -> result=0, iter_count=0, h_start one cycle later.
REQ-038 reset driven low mid-run between clock edges -> all outputs 0 immediately.
REQ-039 With RBM_SCHED_TIMEOUT_EN and timeout_cycles=256, h_done never asserted -> error=1 and IDLE after 256 H_RUN cycles; without the macro, busy stays 1 and error stays 0.
